// File: rtl/nmr_voter.sv
// N-modular-redundancy majority voter with adaptive replica count and
// per-replica disagreement tracking that condemns persistently divergent replicas.
module nmr_voter #(
  parameter int W        = 4,
  parameter int N        = 5,
  parameter int FAULT_TH = 3,
  parameter int LO_TH    = 4,
  parameter int HI_TH    = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [N*W-1:0] data_in,
  input  logic [1:0]     mode,
  input  logic [3:0]     err_rate,
  input  logic           clr_fault,
  output logic           out_valid,
  output logic [W-1:0]   data_out,
  output logic           no_majority,
  output logic [N-1:0]   fault,
  output logic [N-1:0]   active,
  output logic [1:0]     state_o
);

  typedef enum logic [1:0] {
    ST_SIMPLEX = 2'd0,
    ST_TMR     = 2'd1,
    ST_FULL    = 2'd2,
    ST_SLEEP   = 2'd3
  } state_t;

  localparam logic [3:0] LO_TH4    = 4'(LO_TH);
  localparam logic [3:0] HI_TH4    = 4'(HI_TH);
  localparam logic [3:0] FAULT_TH4 = 4'(FAULT_TH);
  localparam logic [3:0] N4        = 4'(N);

  state_t         state_q, state_d;
  logic [N-1:0]   fault_q;
  logic [3:0]     cnt_q [N];
  logic [W-1:0]   data_out_q;
  logic           out_valid_q;
  logic           no_maj_q;

  logic [W-1:0]   word [N];
  logic [3:0]     cnt_inc [N];
  logic [N-1:0]   disagree;
  logic [N-1:0]   act;
  logic [3:0]     req_cnt;
  logic [3:0]     sel_cnt;
  logic [3:0]     a_cnt;
  logic [3:0]     k_cnt;
  logic           have_win;
  logic [W-1:0]   win_word;
  logic           vote_en;
  logic           upd_cnt;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rep
      assign word[gi]     = data_in[gi*W +: W];
      assign cnt_inc[gi]  = (cnt_q[gi] == 4'hF) ? 4'hF : cnt_q[gi] + 4'd1;
      assign disagree[gi] = (word[gi] != win_word);
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    unique case (mode)
      2'd1: state_d = ST_FULL;
      2'd2: state_d = ST_SIMPLEX;
      2'd3: state_d = ST_SLEEP;
      default: begin
        if (err_rate < LO_TH4)      state_d = ST_SIMPLEX;
        else if (err_rate < HI_TH4) state_d = ST_TMR;
        else                        state_d = ST_FULL;
      end
    endcase
  end

  always_comb begin
    req_cnt = 4'd0;
    unique case (state_q)
      ST_SIMPLEX: req_cnt = 4'd1;
      ST_TMR:     req_cnt = 4'd3;
      ST_FULL:    req_cnt = N4;
      default:    req_cnt = 4'd0;
    endcase
  end

  // Healthy replicas are enlisted lowest index first until the required count is met.
  always_comb begin
    act     = '0;
    sel_cnt = 4'd0;
    for (int i = 0; i < N; i++) begin
      if (!fault_q[i] && (sel_cnt < req_cnt)) begin
        act[i]  = 1'b1;
        sel_cnt = sel_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    a_cnt    = 4'd0;
    k_cnt    = 4'd0;
    have_win = 1'b0;
    win_word = '0;
    for (int i = 0; i < N; i++) begin
      if (act[i]) a_cnt = a_cnt + 4'd1;
    end
    for (int i = 0; i < N; i++) begin
      k_cnt = 4'd0;
      for (int j = 0; j < N; j++) begin
        if (act[j] && (word[j] == word[i])) k_cnt = k_cnt + 4'd1;
      end
      if (act[i] && !have_win && ({k_cnt, 1'b0} > {1'b0, a_cnt})) begin
        have_win = 1'b1;
        win_word = word[i];
      end
    end
  end

  assign vote_en = in_valid && (state_q != ST_SLEEP);
  // Small votes cannot tell which replica is wrong, so only A >= 3 may blame anyone.
  assign upd_cnt = vote_en && have_win && (a_cnt >= 4'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_TMR;
      fault_q     <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      no_maj_q    <= 1'b0;
      for (int i = 0; i < N; i++) cnt_q[i] <= 4'd0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= vote_en && have_win;
      no_maj_q    <= vote_en && !have_win;
      if (vote_en && have_win) data_out_q <= win_word;
      if (clr_fault) begin
        fault_q <= '0;
        for (int i = 0; i < N; i++) cnt_q[i] <= 4'd0;
      end else if (upd_cnt) begin
        for (int i = 0; i < N; i++) begin
          if (act[i]) begin
            if (disagree[i]) begin
              cnt_q[i] <= cnt_inc[i];
              if (cnt_inc[i] >= FAULT_TH4) fault_q[i] <= 1'b1;
            end else begin
              cnt_q[i] <= 4'd0;
            end
          end
        end
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign data_out    = data_out_q;
  assign no_majority = no_maj_q;
  assign fault       = fault_q;
  assign active      = act;
  assign state_o     = state_q;

endmodule

// File: tb/tb_nmr_voter.sv
// Directed-vector bench for nmr_voter at N=5, W=4, FAULT_TH=3, LO_TH=4, HI_TH=10.
module tb_nmr_voter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [19:0] data_in;
  logic [1:0]  mode;
  logic [3:0]  err_rate;
  logic        clr_fault;
  logic        out_valid;
  logic [3:0]  data_out;
  logic        no_majority;
  logic [4:0]  fault;
  logic [4:0]  active;
  logic [1:0]  state_o;

  int n_tests = 0;
  int n_fail  = 0;

  nmr_voter #(.W(4), .N(5), .FAULT_TH(3), .LO_TH(4), .HI_TH(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .data_in     (data_in),
    .mode        (mode),
    .err_rate    (err_rate),
    .clr_fault   (clr_fault),
    .out_valid   (out_valid),
    .data_out    (data_out),
    .no_majority (no_majority),
    .fault       (fault),
    .active      (active),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  initial begin
    rst = 1'b1; mode = 2'd0; err_rate = 4'd5; in_valid = 1'b0;
    clr_fault = 1'b0; data_in = 20'hAAAAA;
    tick(); tick();
    rst = 1'b0;
    chk("rst_state", 32'(state_o), 32'd1);
    chk("rst_active", 32'(active), 32'b00111);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_fault", 32'(fault), 32'b00000);

    // TMR vote, all replicas agree
    in_valid = 1'b1; tick();
    chk("tmr_out_valid", 32'(out_valid), 32'd1);
    chk("tmr_data_out", 32'(data_out), 32'hA);
    chk("tmr_state", 32'(state_o), 32'd1);

    // move to FULL, replica 1 disagrees for three samples
    in_valid = 1'b0; err_rate = 4'd12; tick();
    chk("full_state", 32'(state_o), 32'd2);
    chk("full_active", 32'(active), 32'b11111);
    data_in = 20'hAAA3A; in_valid = 1'b1; tick();
    chk("full_s1_data", 32'(data_out), 32'hA);
    chk("full_s1_fault", 32'(fault), 32'b00000);
    tick();
    chk("full_s2_fault", 32'(fault), 32'b00000);
    tick();
    chk("full_s3_fault", 32'(fault), 32'b00010);
    chk("full_s3_active", 32'(active), 32'b11101);

    // err_rate threshold boundaries
    in_valid = 1'b0; err_rate = 4'd10; tick();
    chk("err10_state", 32'(state_o), 32'd2);
    err_rate = 4'd9; tick();
    chk("err9_state", 32'(state_o), 32'd1);
    chk("err9_active", 32'(active), 32'b01101);
    err_rate = 4'd4; tick();
    chk("err4_state", 32'(state_o), 32'd1);
    err_rate = 4'd3; tick();
    chk("err3_state", 32'(state_o), 32'd0);
    chk("err3_active", 32'(active), 32'b00001);
    err_rate = 4'd12; tick();
    chk("err12_active", 32'(active), 32'b11101);

    // no strict majority among four active replicas
    data_in = 20'h32211; in_valid = 1'b1; tick();
    chk("nomaj_pulse", 32'(no_majority), 32'd1);
    chk("nomaj_out_valid", 32'(out_valid), 32'd0);
    chk("nomaj_data_hold", 32'(data_out), 32'hA);
    in_valid = 1'b0; tick();
    chk("nomaj_clear", 32'(no_majority), 32'd0);

    // forced SIMPLEX, then SLEEP
    mode = 2'd2; tick();
    chk("simplex_state", 32'(state_o), 32'd0);
    chk("simplex_active", 32'(active), 32'b00001);
    data_in = 20'hFFFF5; in_valid = 1'b1; tick();
    chk("simplex_data", 32'(data_out), 32'h5);
    chk("simplex_out_valid", 32'(out_valid), 32'd1);
    chk("simplex_fault", 32'(fault), 32'b00010);
    mode = 2'd3; tick();
    chk("sleep_state", 32'(state_o), 32'd3);
    chk("sleep_active", 32'(active), 32'b00000);
    tick();
    chk("sleep_out_valid", 32'(out_valid), 32'd0);
    chk("sleep_data_hold", 32'(data_out), 32'h5);
    chk("sleep_no_maj", 32'(no_majority), 32'd0);

    // clr_fault while replica 1 still disagrees; counter must restart from 0
    mode = 2'd1; in_valid = 1'b0; tick();
    chk("forced_full_state", 32'(state_o), 32'd2);
    data_in = 20'hAAA3A; in_valid = 1'b1; clr_fault = 1'b1; tick();
    chk("clr_fault", 32'(fault), 32'b00000);
    chk("clr_state_kept", 32'(state_o), 32'd2);
    clr_fault = 1'b0;
    chk("clr_active", 32'(active), 32'b11111);
    tick();
    chk("clr_s1_fault", 32'(fault), 32'b00000);
    tick();
    chk("clr_s2_fault", 32'(fault), 32'b00000);
    tick();
    chk("clr_s3_fault", 32'(fault), 32'b00010);

    // reset beats clr_fault and discards the in-flight sample
    rst = 1'b1; clr_fault = 1'b1; data_in = 20'h55555; tick();
    rst = 1'b0; clr_fault = 1'b0; in_valid = 1'b0;
    chk("rst2_state", 32'(state_o), 32'd1);
    chk("rst2_data_out", 32'(data_out), 32'h0);
    chk("rst2_out_valid", 32'(out_valid), 32'd0);
    chk("rst2_no_maj", 32'(no_majority), 32'd0);
    chk("rst2_fault", 32'(fault), 32'b00000);
    chk("rst2_active", 32'(active), 32'b00111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
